// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store memory access unit.
// Holds FSM states, access-size codes, byte-enable patterns and helpers.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    ERR
  } state_e;

  localparam logic [2:0] LT_WORD  = 3'b000;
  localparam logic [2:0] LT_HALF  = 3'b001;
  localparam logic [2:0] LT_BYTE  = 3'b010;
  localparam logic [2:0] LT_HALFU = 3'b011;
  localparam logic [2:0] LT_BYTEU = 3'b100;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE    = 4'b0001;

  function automatic logic is_byte(logic [2:0] lt);
    return (lt == LT_BYTE) || (lt == LT_BYTEU);
  endfunction

  function automatic logic is_half(logic [2:0] lt);
    return (lt == LT_HALF) || (lt == LT_HALFU);
  endfunction

  // Codes 101-111 fall through to word rules.
  function automatic logic misalign(logic [2:0] lt, logic [1:0] off);
    if (is_byte(lt)) return 1'b0;
    if (is_half(lt)) return off[0];
    return off != 2'b00;
  endfunction

  function automatic logic [3:0] store_be(logic [2:0] lt, logic [1:0] off);
    if (is_byte(lt)) return BE_BYTE << off;
    if (is_half(lt)) return off[1] ? BE_HALF_HI : BE_HALF_LO;
    return BE_WORD;
  endfunction

endpackage

// File: rtl/load_align.sv
// Moves the addressed byte/half of a read word down to bit 0 and
// fills the upper bits with sign or zero so bit 31 carries the sign.
module load_align
  import mem_access_pkg::*;
#(
  parameter int N_Bits = 32
) (
  input  logic [N_Bits-1:0] rdata_i,
  input  logic [1:0]        off_i,
  input  logic [2:0]        lt_i,
  output logic [N_Bits-1:0] result_o
);

  logic [N_Bits-1:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  // Select element and extend it according to the access type.
  always_comb begin
    result_o = rdata_i;
    case (lt_i)
      LT_BYTE:  result_o = {{(N_Bits-8){shifted[7]}}, shifted[7:0]};
      LT_BYTEU: result_o = {{(N_Bits-8){1'b0}}, shifted[7:0]};
      LT_HALF:  result_o = {{(N_Bits-16){shifted[15]}}, shifted[15:0]};
      LT_HALFU: result_o = {{(N_Bits-16){1'b0}}, shifted[15:0]};
      default:  result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the core pipeline and a word-wide memory.
// One access in flight; stalls the core until the access resolves.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int N_Bits = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [N_Bits-1:0] req_wdata,
  input  logic [2:0]        Loadtype,
  output logic              stall,
  output logic [N_Bits-1:0] Result,
  output logic              rdata_valid,
  output logic              misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N_Bits-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [N_Bits-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [N_Bits-1:0] wdata_q;
  logic [2:0]        lt_q;
  logic [N_Bits-1:0] result_q;
  logic [N_Bits-1:0] aligned;
  logic              bad;
  logic              accept;
  logic              busy;

  assign bad    = misalign(Loadtype, req_addr[1:0]);
  assign accept = (state_q == IDLE) && req_valid && !bad;
  assign busy   = (state_q == BUSY);

  // Next-state decode for the access sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid) state_d = bad ? ERR : BUSY;
      BUSY: if (mem_ready) state_d = DONE;
      DONE: state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture the request once accepted; later req_* changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lt_q    <= LT_WORD;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      lt_q    <= Loadtype;
    end
  end

  load_align #(.N_Bits(N_Bits)) u_align (
    .rdata_i  (mem_rdata),
    .off_i    (addr_q[1:0]),
    .lt_i     (lt_q),
    .result_o (aligned)
  );

  // Load result is taken on the memory handshake and held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           result_q <= '0;
    else if (busy && mem_ready && !we_q) result_q <= aligned;
  end

  // Store data is replicated across every lane the element can occupy.
  always_comb begin
    mem_wdata = wdata_q;
    if (is_byte(lt_q))      mem_wdata = {(N_Bits/8){wdata_q[7:0]}};
    else if (is_half(lt_q)) mem_wdata = {(N_Bits/16){wdata_q[15:0]}};
  end

  assign stall       = req_valid && ((state_q == IDLE) || busy);
  assign Result      = result_q;
  assign rdata_valid = (state_q == DONE) && !we_q;
  assign misaligned  = (state_q == ERR);
  assign mem_req     = busy;
  assign mem_we      = busy && we_q;
  assign mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_be      = (busy && we_q) ? store_be(lt_q, addr_q[1:0]) : BE_NONE;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter N_Bits, default 32, data width; only 32 is supported.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  core load/store request.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_addr  input  ADDR_W  byte address.
REQ-008 req_wdata  input  N_Bits  store data, element in low bits.
REQ-009 Loadtype  input  3  access size/sign: 000 word, 001 half signed, 010 byte signed, 011 half unsigned, 100 byte unsigned.
REQ-010 stall  output  1  freeze core pipeline.
REQ-011 Result  output  N_Bits  aligned load data to the load-extend stage.
REQ-012 rdata_valid  output  1  Result valid this cycle.
REQ-013 misaligned  output  1  one-cycle misaligned-access flag.
REQ-014 mem_req, mem_we  output  1 each  memory/cache request and direction.
REQ-015 mem_addr  output  ADDR_W  word address, bits[1:0]=00.
REQ-016 mem_wdata  output  N_Bits; mem_be  output  4  byte enables.
REQ-017 mem_ready  input  1; mem_rdata  input  N_Bits  read word, valid when mem_ready=1.

Function
REQ-018 FSM states IDLE, BUSY, DONE, ERR.
REQ-019 IDLE: req_valid=1 and aligned -> latch req_we/req_addr/req_wdata/Loadtype, go BUSY; misaligned -> ERR; else stay.
REQ-020 Misaligned: half with addr[0]=1, word with addr[1:0]!=00; byte never misaligned; Loadtype 101-111 treated as word.
REQ-021 BUSY: mem_req=1, outputs from latched request; mem_ready=1 -> capture mem_rdata, go DONE; else stay.
REQ-022 DONE: rdata_valid=1 for loads (0 for stores), stall=0, mem_req=0, go IDLE unconditionally.
REQ-023 ERR: misaligned=1, stall=0, no memory request, go IDLE.
REQ-024 stall=1 when req_valid=1 and state is IDLE or BUSY; stall=0 otherwise.
REQ-025 Latency: minimum 2 stall cycles (IDLE, BUSY with mem_ready=1); each extra mem_ready=0 cycle adds one.
REQ-026 req_* changes and req_valid deassertion during BUSY are ignored; an accepted transaction always completes.
REQ-027 Load alignment: element at addr[1:0] byte offset shifted to Result[7:0] (byte) or Result[15:0] (half); word passes unshifted.
REQ-028 Upper unused Result bits filled with element sign bit for signed types, zero for unsigned, so the downstream extend stage is correct using Result[31] as sign.
REQ-029 Result holds its last value outside DONE.
REQ-030 Store mem_be: word 1111; half offset0 0011, offset2 1100; byte 0001<<addr[1:0]; mem_be=0000 for loads and when mem_req=0.
REQ-031 Store mem_wdata: byte replicated to all four lanes, half replicated to both halves, word unchanged.
REQ-032 mem_addr = {latched addr[ADDR_W-1:2], 2'b00}.

Reset
REQ-033 On rst: state IDLE; stall, rdata_valid, misaligned, mem_req, mem_we = 0; mem_be=0000; Result, mem_addr, mem_wdata = 0.
REQ-034 rst asserted in BUSY aborts immediately; mem_req drops asynchronously; no DONE pulse follows.

Structure
REQ-035 Package mem_access_pkg holds FSM state enum, Loadtype localparams (LT_WORD, LT_HALF, LT_BYTE, LT_HALFU, LT_BYTEU), byte-enable constants.
REQ-036 Read alignment and fill (REQ-027/028) in combinational sub-module load_align.

Verification
REQ-037 Load byte signed, addr 0x103, mem_rdata 0x80FF_1234, mem_ready first BUSY cycle -> stall 2 cycles, DONE Result=0xFFFF_FF80, rdata_valid=1.
REQ-038 Load half unsigned, addr 0x102, mem_rdata 0xBEEF_0000, mem_ready after 3 wait cycles -> stall 5 cycles, Result=0x0000_BEEF, mem_addr=0x100.
REQ-039 Store byte 0xA5 to addr 0x201 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5_A5A5, mem_addr=0x200.
REQ-040 Load word addr 0x102 -> ERR: misaligned=1 one cycle, mem_req never asserted, stall released.
REQ-041 rst asserted during BUSY -> mem_req=0 immediately, no rdata_valid; next request completes normally.
REQ-042 Back-to-back loads with req_valid held, changing req_addr during BUSY -> first load uses original address; second accepted in IDLE after DONE.
